pipeline_mem_responder: RTL

Memory-side responder for the pipelined datapath's instruction and data ports. It arbitrates single-word fetch and load/store requests onto one RAM port and returns registered one-cycle `ihit`/`dhit` pulses, which the hazard unit consumes to drive stall and flush decisions. It holds the LL/SC link register that resolves `datomic` accesses. It sits between the datapath and the RAM model, in place of a cache in the single-core build.

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/link_register.sv | 35 +++
 rtl/pipeline_mem_responder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake status, data word, and the responder FSM
// state so that benches can probe the controller by name.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DACC  = 3'd1,
        IACC  = 3'd2,
        DDONE = 3'd3,
        IDONE = 3'd4
    } mresp_state_t;

    // Values returned on dmemload for a store-conditional.
    localparam word_t SC_PASS = 32'd1;
    localparam word_t SC_FAIL = 32'd0;

endpackage

// File: rtl/link_register.sv
// LL/SC reservation: one valid bit plus the reserved word address.
// A clear in the same cycle as a set always wins.
import cpu_types_pkg::*;

module link_register (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  i_set,
    input  logic  i_clr,
    input  word_t i_set_addr,
    input  word_t i_cmp_addr,
    output logic  o_valid,
    output logic  o_match
);

    logic  r_valid;
    word_t r_addr;

    // Reservation update: clear has priority over set.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_set) begin
            r_valid <= 1'b1;
            r_addr  <= i_set_addr;
        end
    end

    assign o_valid = r_valid;
    assign o_match = r_valid && (r_addr == i_cmp_addr);

endmodule

// File: rtl/pipeline_mem_responder.sv
// Single-port memory responder for the pipelined core: data requests win
// arbitration over fetches, each access ends with a one-cycle hit pulse,
// and LL/SC is resolved against a local link register.
import cpu_types_pkg::*;

module pipeline_mem_responder #(
    parameter bit LINK_EN = 1'b1
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      halt,
    input  logic      imemREN,
    input  word_t     imemaddr,
    output word_t     imemload,
    output logic      ihit,
    input  logic      dmemREN,
    input  logic      dmemWEN,
    input  logic      datomic,
    input  word_t     dmemaddr,
    input  word_t     dmemstore,
    output word_t     dmemload,
    output logic      dhit,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    mresp_state_t r_state;
    mresp_state_t w_state_next;

    logic  r_dwen;       // data request latched as a write (REN+WEN counts as write)
    logic  r_datomic;    // data request latched as LL/SC
    word_t r_dload;
    word_t r_iload;

    logic  w_access;
    logic  w_dreq;
    logic  w_sc_fail;
    logic  w_link_match;
    logic  w_link_valid;
    logic  w_link_set;
    logic  w_link_clr_evt;
    logic  w_lat_dload;
    word_t w_dload_val;
    logic  w_lat_iload;

    assign w_access  = (ramstate == ACCESS);
    assign w_dreq    = dmemREN | dmemWEN;
    // An SC without a matching reservation never reaches the RAM.
    assign w_sc_fail = LINK_EN && dmemWEN && datomic && !w_link_match;

    link_register u_link (
        .CLK        (CLK),
        .nRST       (nRST),
        .i_set      (w_link_set),
        .i_clr      (w_link_clr_evt | halt),
        .i_set_addr (dmemaddr),
        .i_cmp_addr (dmemaddr),
        .o_valid    (w_link_valid),
        .o_match    (w_link_match)
    );

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, RAM strobes, hit pulses and latch/link enables.
    always_comb begin
        w_state_next   = r_state;
        ramREN         = 1'b0;
        ramWEN         = 1'b0;
        ramaddr        = '0;
        ramstore       = '0;
        ihit           = 1'b0;
        dhit           = 1'b0;
        w_lat_dload    = 1'b0;
        w_dload_val    = r_dload;
        w_lat_iload    = 1'b0;
        w_link_set     = 1'b0;
        w_link_clr_evt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dreq) begin
                    if (w_sc_fail) begin
                        w_state_next   = DDONE;
                        w_lat_dload    = 1'b1;
                        w_dload_val    = SC_FAIL;
                        w_link_clr_evt = 1'b1;
                    end else begin
                        w_state_next = DACC;
                    end
                end else if (imemREN && !halt) begin
                    w_state_next = IACC;
                end
            end
            DACC: begin
                ramaddr  = dmemaddr;
                ramstore = dmemstore;
                ramWEN   = r_dwen;
                ramREN   = !r_dwen;
                if (w_access) begin
                    w_state_next = DDONE;
                    if (!r_dwen) begin
                        w_lat_dload = 1'b1;
                        w_dload_val = ramload;
                        w_link_set  = LINK_EN && r_datomic;
                    end else if (r_datomic) begin
                        w_lat_dload    = 1'b1;
                        w_dload_val    = SC_PASS;
                        w_link_clr_evt = 1'b1;
                    end else begin
                        // A plain store to the reserved word breaks the link.
                        w_link_clr_evt = w_link_match;
                    end
                end
            end
            IACC: begin
                ramaddr = imemaddr;
                ramREN  = 1'b1;
                if (w_access) begin
                    w_state_next = IDONE;
                    w_lat_iload  = 1'b1;
                end
            end
            DDONE: begin
                dhit         = 1'b1;
                w_state_next = IDLE;
            end
            IDONE: begin
                ihit         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Request qualifiers captured at arbitration and the returned words.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_dwen    <= 1'b0;
            r_datomic <= 1'b0;
            r_dload   <= '0;
            r_iload   <= '0;
        end else begin
            if (r_state == IDLE && w_dreq) begin
                r_dwen    <= dmemWEN;
                r_datomic <= datomic;
            end
            if (w_lat_dload) begin
                r_dload <= w_dload_val;
            end
            if (w_lat_iload) begin
                r_iload <= ramload;
            end
        end
    end

    assign dmemload = r_dload;
    assign imemload = r_iload;

endmodule
